shiftreg_universal: RTL and testbench
=====================================

Name: shiftreg_universal

Overview:
- Parametrised universal shift register. Successor to the single-bit serial-in/parallel-out shift register.
- Shifts LANES bits per beat, left or right, with logical, arithmetic and rotate modes, plus synchronous parallel load and clear.
- A beat counter and a full flag support serial-to-parallel and parallel-to-serial conversion in the datapath and debug paths (e.g. CSR scan, multiplier/divider operand staging).

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of LANES.
- LANES, 1, bits shifted per beat; 1 <= LANES <= WIDTH/2.
- BEATS, WIDTH/LANES (derived localparam), beats to fill the register.
- CW, $clog2(BEATS+1) (derived localparam), counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- op  in  3  operation select for this cycle (encoding below).
- sin  in  LANES  serial input lanes.
- pin  in  WIDTH  parallel load data.
- out  out  WIDTH  current register contents (registered).
- sout  out  LANES  lanes leaving the register on this cycle's op (combinational from data and op).
- count  out  CW  beats shifted in since last clear/load (registered).
- full  out  1  count == BEATS (combinational from count).

Behaviour:
- Reset: out = 0, count = 0, full = 0. Entered immediately on reset falling; released synchronously at the first clk edge after reset rises. Reset mid-shift discards all state.
- op encoding (applied at posedge clk):
  - 000 HOLD: no change.
  - 001 SHL: data <= {data[WIDTH-LANES-1:0], sin}; count increments.
  - 010 SHR: data <= {sin, data[WIDTH-1:LANES]}; count increments.
  - 011 ROL: data <= {data[WIDTH-LANES-1:0], data[WIDTH-1 -: LANES]}; count unchanged.
  - 100 ROR: data <= {data[LANES-1:0], data[WIDTH-1:LANES]}; count unchanged.
  - 101 LOAD: data <= pin; count <= BEATS.
  - 110 CLEAR: data <= 0; count <= 0.
  - 111 ASR: data <= {{LANES{data[WIDTH-1]}}, data[WIDTH-1:LANES]}; sin ignored; count unchanged.
- count saturates at BEATS: an SHL/SHR with count == BEATS leaves count at BEATS, and the data still shifts.
- sout:
  - data[WIDTH-1 -: LANES] for SHL and ROL.
  - data[LANES-1:0] for SHR, ROR and ASR.
  - data[WIDTH-1 -: LANES] for HOLD, LOAD and CLEAR.
  - Reflects pre-edge data.
- Zero-cycle latency from edge to out. out changes only on a clk edge or on reset assertion.
- Each cycle performs exactly one op; there are no simultaneous events inside the block.
- Illegal parameters (WIDTH % LANES != 0, or LANES > WIDTH/2) fail at elaboration via $error.
- No X propagation from sin on HOLD, ROL, ROR, ASR, LOAD or CLEAR.

Test Plan:
- Reset: WIDTH=8, LANES=1. Hold reset=0 mid-sequence after loading 0xA5 -> out=0x00, count=0, full=0 immediately. After release with op=HOLD, out stays 0x00.
- Deserialize: WIDTH=8, LANES=1. Eight SHL beats with sin=1,0,1,1,0,0,1,0 -> out=0xB2, count=8, full=1. A ninth SHL with sin=1 -> out=0x65, count stays 8.
- Serialize: WIDTH=8, LANES=4.
  - LOAD pin=0x3C -> count=2, full=1.
  - SHL sin=0x0 -> sout=0x3 before the edge; out=0xC0 after.
  - SHL sin=0x0 -> sout=0xC; out=0x00.
- Rotate/ASR: WIDTH=8, LANES=1.
  - LOAD 0x81, then ROL -> out=0x03, count unchanged (8).
  - ROR twice -> 0xC0.
  - ASR -> 0xE0; sin=X tolerated.
- SHR and CLEAR: WIDTH=8, LANES=4.
  - CLEAR, then SHR sin=0xA -> out=0xA0, count=1, full=0.
  - SHR sin=0x5 -> out=0x5A, full=1.
  - CLEAR -> out=0x00, count=0.
- Parameter sweep: WIDTH in {8,32,64}, LANES in {1,2,4}. Random ops checked against a reference model each cycle on out, sout, count and full.

Source files
------------

// File: rtl/shiftreg_universal.sv
// shiftreg_universal: universal shift register moving LANES bits per beat, with
// a saturating beat counter and full flag for serial<->parallel conversion.
module shiftreg_universal #(
   parameter  int WIDTH = 32,
   parameter  int LANES = 1,
   localparam int BEATS = WIDTH / LANES,
   localparam int CW    = $clog2(BEATS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       op,
   input  logic [LANES-1:0] sin,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] out,
   output logic [LANES-1:0] sout,
   output logic [CW-1:0]    count,
   output logic             full
);
   localparam logic [2:0] OP_HOLD  = 3'd0;
   localparam logic [2:0] OP_SHL   = 3'd1;
   localparam logic [2:0] OP_SHR   = 3'd2;
   localparam logic [2:0] OP_ROL   = 3'd3;
   localparam logic [2:0] OP_ROR   = 3'd4;
   localparam logic [2:0] OP_LOAD  = 3'd5;
   localparam logic [2:0] OP_CLEAR = 3'd6;
   localparam logic [2:0] OP_ASR   = 3'd7;
   localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

   generate
      if (LANES < 1 || WIDTH % LANES != 0 || LANES > WIDTH / 2) begin : g_bad_params
         $error("shiftreg_universal: WIDTH must be a multiple of LANES and 1 <= LANES <= WIDTH/2");
      end
   endgenerate

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    count_q, count_d;
   logic             shift_in;

   always_comb begin
      data_d = data_q;
      case (op)
         OP_SHL:   data_d = {data_q[WIDTH-LANES-1:0], sin};
         OP_SHR:   data_d = {sin, data_q[WIDTH-1:LANES]};
         OP_ROL:   data_d = {data_q[WIDTH-LANES-1:0], data_q[WIDTH-1 -: LANES]};
         OP_ROR:   data_d = {data_q[LANES-1:0], data_q[WIDTH-1:LANES]};
         OP_LOAD:  data_d = pin;
         OP_CLEAR: data_d = '0;
         OP_ASR:   data_d = {{LANES{data_q[WIDTH-1]}}, data_q[WIDTH-1:LANES]};
         default:  data_d = data_q;
      endcase
   end

   // Only serial shifts that admit sin count as beats; the count saturates at a full register.
   assign shift_in = (op == OP_SHL) || (op == OP_SHR);

   always_comb
      count_d = (op == OP_LOAD)                     ? BEATS_C :
                (op == OP_CLEAR)                    ? '0 :
                (shift_in && count_q != BEATS_C)    ? count_q + CW'(1) :
                                                      count_q;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         data_q  <= '0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
      end

   assign out   = data_q;
   assign count = count_q;
   assign full  = (count_q == BEATS_C);
   assign sout  = (op == OP_SHR || op == OP_ROR || op == OP_ASR) ? data_q[LANES-1:0]
                                                                 : data_q[WIDTH-1 -: LANES];
endmodule

// File: tb/tb_shiftreg_universal.sv
// tb_shiftreg_universal: directed vector table on 8x1 and 8x4 instances plus a
// randomised reference-model sweep over several WIDTH/LANES combinations.
module tb_shiftreg_universal;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit sweep_en = 1'b0;
   bit done [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   logic [2:0] op_a, op_b;
   logic       sin_a;
   logic [3:0] sin_b;
   logic [7:0] pin_a, pin_b, out_a, out_b;
   logic       sout_a, full_a, full_b;
   logic [3:0] sout_b, cnt_a;
   logic [1:0] cnt_b;

   shiftreg_universal #(.WIDTH(8), .LANES(1)) u_a (
      .clk(clk), .reset(reset), .op(op_a), .sin(sin_a), .pin(pin_a),
      .out(out_a), .sout(sout_a), .count(cnt_a), .full(full_a));

   shiftreg_universal #(.WIDTH(8), .LANES(4)) u_b (
      .clk(clk), .reset(reset), .op(op_b), .sin(sin_b), .pin(pin_b),
      .out(out_b), .sout(sout_b), .count(cnt_b), .full(full_b));

   typedef struct {
      bit         d;
      logic [2:0] op;
      logic [3:0] sin;
      logic [7:0] pin;
      logic [7:0] out;
      logic [3:0] so;
      logic [3:0] cnt;
      logic       full;
   } vec_t;

   vec_t tv [40];
   int   nv;

   task automatic step(input vec_t v);
      @(negedge clk);
      if (v.d) begin
         op_b = v.op; sin_b = v.sin; pin_b = v.pin;
      end else begin
         op_a = v.op; sin_a = v.sin[0]; pin_a = v.pin;
      end
      #1;
      chk($sformatf("%s op%0d sout", v.d ? "b" : "a", v.op), v.d ? 64'(sout_b) : 64'(sout_a), 64'(v.so));
      @(posedge clk);
      #1;
      chk($sformatf("%s op%0d out", v.d ? "b" : "a", v.op), v.d ? 64'(out_b) : 64'(out_a), 64'(v.out));
      chk($sformatf("%s op%0d count", v.d ? "b" : "a", v.op), v.d ? 64'(cnt_b) : 64'(cnt_a), 64'(v.cnt));
      chk($sformatf("%s op%0d full", v.d ? "b" : "a", v.op), v.d ? 64'(full_b) : 64'(full_a), 64'(v.full));
      op_a = 3'd0;
      op_b = 3'd0;
   endtask

   genvar i, j;
   for (i = 0; i < 3; i++) begin : g_w
      for (j = 0; j < 3; j++) begin : g_l
         localparam int W  = (i == 0) ? 8 : (i == 1) ? 32 : 64;
         localparam int L  = 1 << j;
         localparam int BT = W / L;
         localparam int C  = $clog2(BT + 1);
         logic [2:0]   op;
         logic [L-1:0] sin, sout;
         logic [W-1:0] pin, out, md;
         logic [C-1:0] cnt;
         logic         full;
         int           mc;

         shiftreg_universal #(.WIDTH(W), .LANES(L)) u_dut (
            .clk(clk), .reset(reset), .op(op), .sin(sin), .pin(pin),
            .out(out), .sout(sout), .count(cnt), .full(full));

         function automatic logic [W-1:0] nx(input logic [2:0] o, input logic [W-1:0] d,
                                              input logic [L-1:0] s, input logic [W-1:0] p);
            case (o)
               3'd1:    nx = (d << L) | W'(s);
               3'd2:    nx = (d >> L) | (W'(s) << (W - L));
               3'd3:    nx = (d << L) | (d >> (W - L));
               3'd4:    nx = (d >> L) | (d << (W - L));
               3'd5:    nx = p;
               3'd6:    nx = '0;
               3'd7:    nx = W'($signed(d) >>> L);
               default: nx = d;
            endcase
         endfunction

         always @(posedge clk or negedge reset)
            if (!reset) begin
               md <= '0;
               mc <= 0;
            end else begin
               md <= nx(op, md, sin, pin);
               mc <= (op == 3'd5) ? BT : (op == 3'd6) ? 0 : ((op == 3'd1 || op == 3'd2) && mc < BT) ? mc + 1 : mc;
            end

         initial begin
            op = 3'd0; sin = '0; pin = '0;
            wait (sweep_en);
            repeat (150) begin
               @(negedge clk);
               chk($sformatf("sw%0dx%0d out", W, L), 64'(out), 64'(md));
               chk($sformatf("sw%0dx%0d count", W, L), 64'(cnt), 64'(mc));
               chk($sformatf("sw%0dx%0d full", W, L), 64'(full), 64'(mc == BT));
               op  = 3'($urandom_range(0, 7));
               sin = L'($urandom);
               pin = W'({$urandom, $urandom});
               #1;
               chk($sformatf("sw%0dx%0d sout op%0d", W, L, op), 64'(sout),
                   64'((op == 3'd2 || op == 3'd4 || op == 3'd7) ? md[L-1:0] : md[W-1 -: L]));
            end
            op = 3'd0;
            done[i*3+j] = 1'b1;
         end
      end
   end

   initial begin
      bit all;
      reset = 1'b0;
      op_a = 3'd0; sin_a = 1'b0; pin_a = 8'h00;
      op_b = 3'd0; sin_b = 4'h0; pin_b = 8'h00;
      #12;
      chk("rst out_a", 64'(out_a), 64'h00);
      chk("rst cnt_a", 64'(cnt_a), 64'd0);
      chk("rst full_a", 64'(full_a), 64'd0);
      chk("rst out_b", 64'(out_b), 64'h00);
      chk("rst full_b", 64'(full_b), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      // Reset asserted mid-cycle after a load and a shift must clear immediately.
      step('{0, 3'd5, 4'h0, 8'hA5, 8'hA5, 4'h0, 4'd8, 1'b1});
      @(negedge clk);
      op_a = 3'd1; sin_a = 1'b1;
      @(posedge clk);
      #1;
      chk("pre-reset out_a", 64'(out_a), 64'h4B);
      #2;
      reset = 1'b0;
      #1;
      chk("async rst out_a", 64'(out_a), 64'h00);
      chk("async rst cnt_a", 64'(cnt_a), 64'd0);
      chk("async rst full_a", 64'(full_a), 64'd0);
      op_a = 3'd0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("post-rst hold out_a", 64'(out_a), 64'h00);
      chk("post-rst hold cnt_a", 64'(cnt_a), 64'd0);

      nv = 0;
      tv[nv++] = '{0, 3'd1, 4'h1, 8'h00, 8'h01, 4'h0, 4'd1, 1'b0};
      tv[nv++] = '{0, 3'd1, 4'h0, 8'h00, 8'h02, 4'h0, 4'd2, 1'b0};
      tv[nv++] = '{0, 3'd1, 4'h1, 8'h00, 8'h05, 4'h0, 4'd3, 1'b0};
      tv[nv++] = '{0, 3'd1, 4'h1, 8'h00, 8'h0B, 4'h0, 4'd4, 1'b0};
      tv[nv++] = '{0, 3'd1, 4'h0, 8'h00, 8'h16, 4'h0, 4'd5, 1'b0};
      tv[nv++] = '{0, 3'd1, 4'h0, 8'h00, 8'h2C, 4'h0, 4'd6, 1'b0};
      tv[nv++] = '{0, 3'd1, 4'h1, 8'h00, 8'h59, 4'h0, 4'd7, 1'b0};
      tv[nv++] = '{0, 3'd1, 4'h0, 8'h00, 8'hB2, 4'h0, 4'd8, 1'b1};
      tv[nv++] = '{0, 3'd1, 4'h1, 8'h00, 8'h65, 4'h1, 4'd8, 1'b1};
      tv[nv++] = '{0, 3'd5, 4'h0, 8'h81, 8'h81, 4'h0, 4'd8, 1'b1};
      tv[nv++] = '{0, 3'd3, 4'h0, 8'h00, 8'h03, 4'h1, 4'd8, 1'b1};
      tv[nv++] = '{0, 3'd4, 4'h0, 8'h00, 8'h81, 4'h1, 4'd8, 1'b1};
      tv[nv++] = '{0, 3'd4, 4'h0, 8'h00, 8'hC0, 4'h1, 4'd8, 1'b1};
      tv[nv++] = '{0, 3'd7, 4'hx, 8'h00, 8'hE0, 4'h0, 4'd8, 1'b1};
      tv[nv++] = '{0, 3'd0, 4'hx, 8'h00, 8'hE0, 4'h1, 4'd8, 1'b1};
      tv[nv++] = '{0, 3'd6, 4'hx, 8'h00, 8'h00, 4'h1, 4'd0, 1'b0};
      tv[nv++] = '{0, 3'd2, 4'h1, 8'h00, 8'h80, 4'h0, 4'd1, 1'b0};
      tv[nv++] = '{0, 3'd2, 4'h0, 8'h00, 8'h40, 4'h0, 4'd2, 1'b0};
      tv[nv++] = '{1, 3'd5, 4'h0, 8'h3C, 8'h3C, 4'h0, 4'd2, 1'b1};
      tv[nv++] = '{1, 3'd1, 4'h0, 8'h00, 8'hC0, 4'h3, 4'd2, 1'b1};
      tv[nv++] = '{1, 3'd1, 4'h0, 8'h00, 8'h00, 4'hC, 4'd2, 1'b1};
      tv[nv++] = '{1, 3'd6, 4'h0, 8'h00, 8'h00, 4'h0, 4'd0, 1'b0};
      tv[nv++] = '{1, 3'd2, 4'hA, 8'h00, 8'hA0, 4'h0, 4'd1, 1'b0};
      tv[nv++] = '{1, 3'd2, 4'h5, 8'h00, 8'h5A, 4'h0, 4'd2, 1'b1};
      tv[nv++] = '{1, 3'd4, 4'h0, 8'h00, 8'hA5, 4'hA, 4'd2, 1'b1};
      tv[nv++] = '{1, 3'd3, 4'h0, 8'h00, 8'h5A, 4'hA, 4'd2, 1'b1};
      tv[nv++] = '{1, 3'd7, 4'hx, 8'h00, 8'h05, 4'hA, 4'd2, 1'b1};
      tv[nv++] = '{1, 3'd5, 4'hx, 8'h96, 8'h96, 4'h0, 4'd2, 1'b1};
      tv[nv++] = '{1, 3'd7, 4'hx, 8'h00, 8'hF9, 4'h6, 4'd2, 1'b1};
      tv[nv++] = '{1, 3'd6, 4'hx, 8'h00, 8'h00, 4'hF, 4'd0, 1'b0};
      tv[nv++] = '{1, 3'd0, 4'hx, 8'h00, 8'h00, 4'h0, 4'd0, 1'b0};
      for (int k = 0; k < nv; k++) step(tv[k]);

      sweep_en = 1'b1;
      all = 1'b0;
      for (int t = 0; t < 2000 && !all; t++) begin
         @(posedge clk);
         all = 1'b1;
         for (int k = 0; k < 9; k++) if (!done[k]) all = 1'b0;
      end
      total++;
      if (!all) begin
         bad++;
         $display("FAIL sweep timeout got=0 want=1");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
